// File: rtl/result_s2mm_pkg.sv
// Shared constants for result_s2mm: one-hot states, beat/byte geometry and
// the burst-size helper that clips a burst to its cap and, optionally, a 4 KB page.
package result_s2mm_pkg;

   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_ADDR = 5'b00010,
      ST_DATA = 5'b00100,
      ST_RESP = 5'b01000,
      ST_PAGE = 5'b10000
   } state_t;

   localparam int BPB_BYTES     = 32;
   localparam int BPB_SHIFT     = 5;
   localparam int BURST_MAX     = 256;
   localparam int BURST_MAX_4K  = 128;
   localparam int PAGE_4K_BYTES = 4096;

   function automatic logic [8:0] burst_beats(input logic [31:0] remaining,
                                              input logic [11:0] page_offset,
                                              input bit          split_4k);
      logic [31:0] cap;
      logic [31:0] to_page;
      to_page = (32'(PAGE_4K_BYTES) - {20'd0, page_offset}) >> BPB_SHIFT;
      if (split_4k)
         cap = (to_page < 32'(BURST_MAX_4K)) ? to_page : 32'(BURST_MAX_4K);
      else
         cap = 32'(BURST_MAX);
      return 9'((remaining < cap) ? remaining : cap);
   endfunction

endpackage

// File: rtl/result_s2mm_prefetch_fifo.sv
// Two-entry prefetch FIFO holding buffer words between the ring-buffer read
// and the AXI write-data channel; clear empties it synchronously.
module s2mm_prefetch_fifo #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_reg [2];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       count_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_reg == 1'(gi)))
            mem_reg[gi] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push)
            wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)
            rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + 2'(push) - 2'(pop);
      end
   end

   assign count = count_reg;
   assign empty = (count_reg == 2'd0);
   assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/result_s2mm.sv
// Streams a region of the result ring buffer to DDR as AXI write bursts.
// Define RESULT_S2MM_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module result_s2mm
   import result_s2mm_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 42,
   parameter int AXI_ID_WIDTH   = 1,
   parameter int AXI_DATA_WIDTH = 256,
   parameter int WR_ID          = 0,
   parameter int MEM_ADDR_WIDTH = 8,
   parameter int LEN_WIDTH      = 26,
   parameter int SIZE_WIDTH     = 9
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_start,
   output logic                      o_done,
   input  logic [AXI_ADDR_WIDTH-1:0] i_s2mm_base,
   input  logic [LEN_WIDTH-1:0]      i_s2mm_leng,
   input  logic                      i_src_ready,
   output logic                      o_mem_rreq,
   output logic [MEM_ADDR_WIDTH-1:0] o_mem_radd,
   input  logic [AXI_DATA_WIDTH-1:0] i_mem_rdata,
   output logic [AXI_ID_WIDTH-1:0]   o_s2mm_req_id,
   output logic [AXI_ADDR_WIDTH-1:0] o_s2mm_addr,
   output logic [SIZE_WIDTH-1:0]     o_s2mm_size,
   output logic                      o_s2mm_addr_req,
   input  logic                      i_s2mm_addr_ready,
   output logic [AXI_DATA_WIDTH-1:0] o_s2mm_data,
   output logic                      o_s2mm_data_valid,
   input  logic                      i_s2mm_data_ready,
   input  logic                      i_s2mm_done
);

`ifdef RESULT_S2MM_4K_SPLIT_EN
   localparam bit SPLIT_4K = 1'b1;
`else
   localparam bit SPLIT_4K = 1'b0;
`endif

   state_t                    state_reg, state_next;
   logic                      start_prev_reg;
   logic                      done_d1_reg, done_d2_reg, done_reg;
   logic [AXI_ADDR_WIDTH-1:0] base_reg, addr_reg;
   logic [LEN_WIDTH-1:0]      total_reg, issued_reg;
   logic [MEM_ADDR_WIDTH-1:0] rd_beat_reg;
   logic [SIZE_WIDTH-1:0]     size_reg, fetched_reg, sent_reg;
   logic                      inflight_reg;

   logic                      start_edge, done_edge, fire, rreq, data_valid;
   logic [LEN_WIDTH-1:0]      start_beats, cur_issued, cur_total;
   logic [AXI_ADDR_WIDTH-1:0] cur_base, next_addr;
   logic [SIZE_WIDTH-1:0]     next_size;
   logic [1:0]                fifo_count;
   logic                      fifo_empty;
   logic [AXI_DATA_WIDTH-1:0] fifo_head;
   logic [2:0]                occupancy;

   assign start_edge  = i_start && !start_prev_reg;
   assign done_edge   = i_s2mm_done && !done_d1_reg && !done_d2_reg;
   assign start_beats = (i_s2mm_leng >> BPB_SHIFT) + LEN_WIDTH'(|i_s2mm_leng[BPB_SHIFT-1:0]);

   // From IDLE the first burst is sized straight from the inputs being latched.
   always_comb begin
      cur_base   = base_reg;
      cur_issued = issued_reg;
      cur_total  = total_reg;
      if (state_reg == ST_IDLE) begin
         cur_base   = i_s2mm_base;
         cur_issued = '0;
         cur_total  = start_beats;
      end
      next_addr = cur_base + (AXI_ADDR_WIDTH'(cur_issued) << BPB_SHIFT);
      next_size = SIZE_WIDTH'(burst_beats(32'(cur_total - cur_issued), next_addr[11:0], SPLIT_4K));
   end

   s2mm_prefetch_fifo #(.WIDTH(AXI_DATA_WIDTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (state_reg == ST_IDLE),
      .push      (inflight_reg),
      .push_data (i_mem_rdata),
      .pop       (fire),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign data_valid = (state_reg == ST_DATA) && !fifo_empty;
   assign fire       = data_valid && i_s2mm_data_ready;
   // Credit the beat leaving this cycle so a held-high ready sustains 1 beat/cycle.
   assign occupancy  = 3'(fifo_count) + 3'(inflight_reg) - 3'(fire);
   assign rreq       = (state_reg == ST_DATA) && (fetched_reg != size_reg) && (occupancy < 3'd2);

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: if (start_edge && (start_beats != '0)) state_next = ST_ADDR;
         ST_ADDR: if (i_s2mm_addr_ready) state_next = ST_DATA;
         ST_DATA: if (sent_reg == size_reg) state_next = ST_RESP;
         ST_RESP: if (done_edge) state_next = ST_PAGE;
         ST_PAGE: begin
            if (issued_reg == total_reg)
               state_next = ST_IDLE;
            else if (i_src_ready)
               state_next = ST_ADDR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_s2mm_addr_req   = (state_reg == ST_ADDR);
      o_s2mm_data_valid = data_valid;
      o_mem_rreq        = rreq;
      o_mem_radd        = rd_beat_reg;
      o_s2mm_addr       = addr_reg;
      o_s2mm_size       = size_reg;
      o_s2mm_data       = fifo_head;
      o_s2mm_req_id     = AXI_ID_WIDTH'(WR_ID);
      o_done            = done_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         start_prev_reg <= 1'b0;
         done_d1_reg    <= 1'b0;
         done_d2_reg    <= 1'b0;
         done_reg       <= 1'b0;
         base_reg       <= '0;
         addr_reg       <= '0;
         total_reg      <= '0;
         issued_reg     <= '0;
         rd_beat_reg    <= '0;
         size_reg       <= '0;
         fetched_reg    <= '0;
         sent_reg       <= '0;
         inflight_reg   <= 1'b0;
      end else begin
         start_prev_reg <= i_start;
         done_d1_reg    <= i_s2mm_done;
         done_d2_reg    <= done_d1_reg;
         done_reg       <= 1'b0;
         inflight_reg   <= rreq;
         if (rreq) begin
            rd_beat_reg <= rd_beat_reg + 1'b1;
            fetched_reg <= fetched_reg + 1'b1;
         end
         if (fire)
            sent_reg <= sent_reg + 1'b1;
         unique case (state_reg)
            ST_IDLE: begin
               if (start_edge) begin
                  base_reg    <= i_s2mm_base;
                  total_reg   <= start_beats;
                  issued_reg  <= '0;
                  rd_beat_reg <= '0;
                  if (start_beats == '0) begin
                     done_reg <= 1'b1;
                  end else begin
                     addr_reg <= next_addr;
                     size_reg <= next_size;
                  end
               end
            end
            ST_ADDR: begin
               if (i_s2mm_addr_ready) begin
                  issued_reg  <= issued_reg + LEN_WIDTH'(size_reg);
                  fetched_reg <= '0;
                  sent_reg    <= '0;
               end
            end
            ST_PAGE: begin
               if (issued_reg == total_reg) begin
                  done_reg <= 1'b1;
               end else if (i_src_ready) begin
                  addr_reg <= next_addr;
                  size_reg <= next_size;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_result_s2mm.sv
// Scoreboard bench for result_s2mm: a transfer-level model queues expected
// bursts, beats and done pulses; a monitor checks the DUT against them.
module tb_result_s2mm;

   localparam int AW = 42;
   localparam int DW = 256;
   localparam int MW = 8;
   localparam int LW = 26;
   localparam int SW = 9;

   typedef struct {
      logic [AW-1:0] addr;
      int            size;
   } burst_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_start = 1'b0;
   logic          o_done;
   logic [AW-1:0] i_s2mm_base = '0;
   logic [LW-1:0] i_s2mm_leng = '0;
   logic          i_src_ready = 1'b1;
   logic          o_mem_rreq;
   logic [MW-1:0] o_mem_radd;
   logic [DW-1:0] i_mem_rdata = '0;
   logic [0:0]    o_s2mm_req_id;
   logic [AW-1:0] o_s2mm_addr;
   logic [SW-1:0] o_s2mm_size;
   logic          o_s2mm_addr_req;
   logic          i_s2mm_addr_ready = 1'b0;
   logic [DW-1:0] o_s2mm_data;
   logic          o_s2mm_data_valid;
   logic          i_s2mm_data_ready = 1'b0;
   logic          i_s2mm_done = 1'b0;

   always #5 clk = ~clk;

   result_s2mm dut (
      .clk               (clk),
      .reset             (reset),
      .i_start           (i_start),
      .o_done            (o_done),
      .i_s2mm_base       (i_s2mm_base),
      .i_s2mm_leng       (i_s2mm_leng),
      .i_src_ready       (i_src_ready),
      .o_mem_rreq        (o_mem_rreq),
      .o_mem_radd        (o_mem_radd),
      .i_mem_rdata       (i_mem_rdata),
      .o_s2mm_req_id     (o_s2mm_req_id),
      .o_s2mm_addr       (o_s2mm_addr),
      .o_s2mm_size       (o_s2mm_size),
      .o_s2mm_addr_req   (o_s2mm_addr_req),
      .i_s2mm_addr_ready (i_s2mm_addr_ready),
      .o_s2mm_data       (o_s2mm_data),
      .o_s2mm_data_valid (o_s2mm_data_valid),
      .i_s2mm_data_ready (i_s2mm_data_ready),
      .i_s2mm_done       (i_s2mm_done)
   );

   logic [DW-1:0] mem [256];
   burst_t        exp_bursts[$];
   logic [DW-1:0] exp_beats[$];
   int            exp_dones = 0;
   int            n_cmp = 0;
   int            n_fail = 0;
   int            bursts_done = 0;
   int            dones_seen = 0;
   int            xfer_gen = 0;
   int            data_ready_pct = 100;
   int            addr_delay = 0;

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail_event(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
   endtask

   // Reference: split the byte length into beats and bursts by plain arithmetic.
   task automatic model_transfer(input logic [AW-1:0] base, input int leng);
      int            total;
      int            issued;
      int            sz;
      int            cap;
      logic [AW-1:0] a;
      total  = (leng + 31) / 32;
      issued = 0;
      while (issued < total) begin
         a  = base + AW'(issued) * 32;
         sz = total - issued;
         cap = 256;
`ifdef RESULT_S2MM_4K_SPLIT_EN
         cap = 128;
         if ((4096 - int'(a[11:0])) / 32 < cap) cap = (4096 - int'(a[11:0])) / 32;
`endif
         if (sz > cap) sz = cap;
         exp_bursts.push_back('{addr: a, size: sz});
         issued += sz;
      end
      for (int k = 0; k < total; k++) exp_beats.push_back(mem[k % 256]);
      exp_dones++;
   endtask

   // RAM model, AXI slave and done responder.
   initial begin
      logic          rq;
      logic [MW-1:0] ra;
      int            req_wait;
      int            acked;
      int            resp_delay;
      req_wait = 0;
      acked = 0;
      resp_delay = 0;
      forever begin
         @(negedge clk);
         rq = o_mem_rreq;
         ra = o_mem_radd;
         @(posedge clk);
         #1;
         i_mem_rdata = rq ? mem[ra] : rand_word();
         if (o_s2mm_addr_req) begin
            i_s2mm_addr_ready = (req_wait >= addr_delay);
            req_wait++;
         end else begin
            req_wait = 0;
            i_s2mm_addr_ready = ($urandom_range(0, 1) == 1);
         end
         i_s2mm_data_ready = ($urandom_range(0, 99) < data_ready_pct);
         i_s2mm_done = 1'b0;
         if (bursts_done > acked) begin
            if (resp_delay >= 3) begin
               i_s2mm_done = 1'b1;
               acked++;
               resp_delay = 0;
            end else begin
               resp_delay++;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin
      burst_t        b;
      logic          prev_req;
      logic          prev_rdy;
      logic          prev_src;
      logic [AW-1:0] prev_addr;
      logic [SW-1:0] prev_size;
      int            rd_count;
      int            seen_gen;
      int            burst_left;
      int            burst_idx;
      prev_req = 1'b0; prev_rdy = 1'b0; prev_src = 1'b1;
      prev_addr = '0; prev_size = '0;
      rd_count = 0; seen_gen = 0; burst_left = 0; burst_idx = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rd_count = 0;
            burst_left = 0;
            burst_idx = 0;
            prev_req = 1'b0;
         end else begin
            if (seen_gen != xfer_gen) begin
               seen_gen = xfer_gen;
               rd_count = 0;
               burst_idx = 0;
            end
            if (o_mem_rreq) begin
               check("radd", DW'(o_mem_radd), DW'(rd_count % 256));
               rd_count++;
            end
            if (o_s2mm_addr_req && prev_req && !prev_rdy) begin
               check("addr_stable", DW'(o_s2mm_addr), DW'(prev_addr));
               check("size_stable", DW'(o_s2mm_size), DW'(prev_size));
            end
            if (o_s2mm_addr_req && !prev_req && burst_idx > 0)
               check("src_gate", DW'(prev_src), DW'(1));
            if (o_s2mm_addr_req && i_s2mm_addr_ready) begin
               if (exp_bursts.size() == 0) begin
                  fail_event("addr_unexpected");
               end else begin
                  b = exp_bursts.pop_front();
                  check("burst_addr", DW'(o_s2mm_addr), DW'(b.addr));
                  check("burst_size", DW'(o_s2mm_size), DW'(b.size));
                  check("req_id", DW'(o_s2mm_req_id), DW'(0));
                  burst_left = b.size;
               end
               burst_idx++;
            end
            if (o_s2mm_data_valid && i_s2mm_data_ready) begin
               if (exp_beats.size() == 0)
                  fail_event("beat_unexpected");
               else
                  check("beat", o_s2mm_data, exp_beats.pop_front());
               burst_left--;
               if (burst_left == 0) bursts_done++;
            end
            if (o_done) begin
               if (exp_dones == 0) begin
                  fail_event("done_unexpected");
               end else begin
                  exp_dones--;
                  dones_seen++;
               end
            end
            prev_req  = o_s2mm_addr_req;
            prev_rdy  = i_s2mm_addr_ready;
            prev_addr = o_s2mm_addr;
            prev_size = o_s2mm_size;
            prev_src  = i_src_ready;
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_addr_req", DW'(o_s2mm_addr_req), '0);
      check("rst_rreq", DW'(o_mem_rreq), '0);
      check("rst_valid", DW'(o_s2mm_data_valid), '0);
      check("rst_done", DW'(o_done), '0);
      check("rst_addr", DW'(o_s2mm_addr), '0);
      check("rst_size", DW'(o_s2mm_size), '0);
      check("rst_radd", DW'(o_mem_radd), '0);
   endtask

   // Issues one transfer, checks first-response latency, optionally holds
   // i_src_ready low after the first burst and fires a stray start edge.
   task automatic run_transfer(input logic [AW-1:0] base, input int leng,
                               input int src_low, input bit restart_mid);
      int cyc;
      int target;
      int base_bursts;
      model_transfer(base, leng);
      xfer_gen++;
      target = dones_seen + 1;
      base_bursts = bursts_done;
      if (src_low > 0) i_src_ready = 1'b0;
      i_s2mm_base = base;
      i_s2mm_leng = LW'(leng);
      i_start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #2;
         cyc++;
      end while (!((leng == 0) ? o_done : o_s2mm_addr_req) && cyc < 10);
      check((leng == 0) ? "done_latency" : "req_latency", DW'(cyc), DW'(1));
      i_start = 1'b0;
      if (restart_mid) begin
         cyc = 0;
         while (!o_s2mm_data_valid && cyc < 2000) begin @(posedge clk); #2; cyc++; end
         i_s2mm_base = base + 42'h10000;
         i_s2mm_leng = LW'(leng + 4096);
         i_start = 1'b1;
         repeat (2) @(posedge clk);
         #2 i_start = 1'b0;
      end
      if (src_low > 0) begin
         cyc = 0;
         while (bursts_done == base_bursts && cyc < 20000) begin @(posedge clk); #2; cyc++; end
         repeat (src_low) @(posedge clk);
         #2 i_src_ready = 1'b1;
      end
      cyc = 0;
      while (dones_seen < target && cyc < 20000) begin @(posedge clk); #2; cyc++; end
      if (dones_seen < target) fail_event("transfer_timeout");
      repeat (4) @(posedge clk);
      #2;
      check("bursts_left", DW'(exp_bursts.size()), '0);
      check("beats_left", DW'(exp_beats.size()), '0);
      $display("transfer base=%0h leng=%0d done, compared=%0d mismatched=%0d", base, leng, n_cmp, n_fail);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 256; i++) mem[i] = rand_word();
      repeat (3) @(posedge clk);
      #2 check_reset_outputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      run_transfer(42'h1000, 8192, 0, 1'b0);
      run_transfer(42'h20000, 100, 0, 1'b0);
      run_transfer(42'h30000, 0, 0, 1'b0);
      data_ready_pct = 50;
      run_transfer(42'h0, 16384, 20, 1'b0);
      data_ready_pct = 100;
      addr_delay = 5;
      run_transfer(42'h8000, 3000, 0, 1'b1);
      addr_delay = 0;

      // Reset in the middle of a data phase, then a fresh transfer.
      model_transfer(42'h0, 4096);
      xfer_gen++;
      i_s2mm_base = 42'h0;
      i_s2mm_leng = LW'(4096);
      i_start = 1'b1;
      cyc = 0;
      while (!o_s2mm_data_valid && cyc < 100) begin @(posedge clk); #2; cyc++; end
      i_start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 check_reset_outputs();
      exp_bursts.delete();
      exp_beats.delete();
      exp_dones = 0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      run_transfer(42'h4000, 1000, 0, 1'b0);

      for (int t = 0; t < 4; t++) begin
         data_ready_pct = $urandom_range(30, 100);
         addr_delay = $urandom_range(0, 3);
         run_transfer(AW'($urandom_range(0, 32767)) * 32, $urandom_range(1, 4000), 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
